// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding and shared constants for the ALU, its issue stage
// and the formal harness.
package alu_pkg;

    typedef enum logic [1:0] {
        OPC_ADD = 2'd0,
        OPC_SUB = 2'd1,
        OPC_AND = 2'd2,
        OPC_OR  = 2'd3
    } opc_t;

    localparam int ALU_LATENCY = 1;
    localparam int WIDTH       = 8;

endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: generic synchronous FIFO with a registered occupancy count;
// push is ignored when full and pop is ignored when empty.
module alu_issue_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [Width-1:0] i_din,
    input  logic             i_pop,
    output logic [Width-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_count == (AW + 1)'(Depth);
    assign o_empty = r_count == '0;
    assign o_dout  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        end
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: queues ALU commands, issues them in order and returns results in order.
// Define ALU_ISSUE_TAG_EN to carry a per-command tag through to the result.
module alu_issue
    import alu_pkg::*;
#(
    parameter int Width = WIDTH,
    parameter int Depth = 4
`ifdef ALU_ISSUE_TAG_EN
    ,
    parameter int TagWidth = 4
`endif
) (
    input  logic             Clk_i,
    input  logic             Reset_n_i,
    input  logic             Cmd_valid_i,
    output logic             Cmd_ready_o,
    input  logic [1:0]       Cmd_opc_i,
    input  logic [Width-1:0] Cmd_a_i,
    input  logic [Width-1:0] Cmd_b_i,
    output logic [1:0]       Alu_opc_o,
    output logic [Width-1:0] Alu_a_o,
    output logic [Width-1:0] Alu_b_o,
    input  logic [Width-1:0] Alu_dout_i,
    input  logic             Alu_ovf_i,
    output logic             Res_valid_o,
    input  logic             Res_ready_i,
    output logic [Width-1:0] Res_data_o,
`ifdef ALU_ISSUE_TAG_EN
    input  logic [TagWidth-1:0] Cmd_tag_i,
    output logic [TagWidth-1:0] Res_tag_o,
`endif
    output logic             Res_ovf_o
);

`ifdef ALU_ISSUE_TAG_EN
    localparam int CmdW = TagWidth + 2 + 2 * Width;
`else
    localparam int CmdW = 2 + 2 * Width;
`endif

    logic [CmdW-1:0]        w_cmd_in;
    logic [CmdW-1:0]        w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_issue;
    logic                   w_res_pop;
    logic                   w_cap;
    logic                   w_wr_idx;
    opc_t                   r_alu_opc;
    logic [Width-1:0]       r_alu_a;
    logic [Width-1:0]       r_alu_b;
    logic [ALU_LATENCY:0]   r_pipe;
    logic [1:0]             r_outst;
    logic [1:0]             r_buf_cnt;
    logic [Width-1:0]       r_buf_data [2];
    logic [1:0]             r_buf_ovf;

`ifdef ALU_ISSUE_TAG_EN
    assign w_cmd_in = {Cmd_tag_i, Cmd_opc_i, Cmd_a_i, Cmd_b_i};
`else
    assign w_cmd_in = {Cmd_opc_i, Cmd_a_i, Cmd_b_i};
`endif

    alu_issue_fifo #(
        .Width(CmdW),
        .Depth(Depth)
    ) u_cmd_fifo (
        .i_clk   (Clk_i),
        .i_rst_n (Reset_n_i),
        .i_push  (Cmd_valid_i),
        .i_din   (w_cmd_in),
        .i_pop   (w_issue),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Outstanding spans issue register, ALU stage and result buffer, so capping
    // it at two means the two-entry buffer can never be overrun.
    assign Cmd_ready_o = !w_full;
    assign w_res_pop   = Res_valid_o && Res_ready_i;
    assign w_issue     = !w_empty && (r_outst < 2'd2 || w_res_pop);
    assign w_cap       = r_pipe[ALU_LATENCY];
    assign w_wr_idx    = w_res_pop ? r_buf_cnt[1] : r_buf_cnt[0];
    assign Alu_opc_o   = r_alu_opc;
    assign Alu_a_o     = r_alu_a;
    assign Alu_b_o     = r_alu_b;
    assign Res_valid_o = r_buf_cnt != 2'd0;
    assign Res_data_o  = r_buf_data[0];
    assign Res_ovf_o   = r_buf_ovf[0];

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_alu_opc <= OPC_ADD;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_pipe    <= '0;
            r_outst   <= '0;
        end else begin
            r_pipe  <= {r_pipe[ALU_LATENCY-1:0], w_issue};
            r_outst <= r_outst + 2'(w_issue) - 2'(w_res_pop);
            if (w_issue) begin
                r_alu_opc <= opc_t'(w_head[2*Width +: 2]);
                r_alu_a   <= w_head[Width +: Width];
                r_alu_b   <= w_head[0 +: Width];
            end
        end
    end

    // Entry 0 is always the oldest result; a pop shifts entry 1 down.
    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_buf_cnt  <= '0;
            r_buf_data <= '{default: '0};
            r_buf_ovf  <= '0;
        end else begin
            r_buf_cnt <= r_buf_cnt + 2'(w_cap) - 2'(w_res_pop);
            if (w_res_pop) begin
                r_buf_data[0] <= r_buf_data[1];
                r_buf_ovf[0]  <= r_buf_ovf[1];
            end
            if (w_cap) begin
                r_buf_data[w_wr_idx] <= Alu_dout_i;
                r_buf_ovf[w_wr_idx]  <= Alu_ovf_i;
            end
        end
    end

`ifdef ALU_ISSUE_TAG_EN
    logic [TagWidth-1:0] r_tag_pipe [ALU_LATENCY+1];
    logic [TagWidth-1:0] r_buf_tag  [2];

    assign Res_tag_o = r_buf_tag[0];

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_tag_pipe <= '{default: '0};
            r_buf_tag  <= '{default: '0};
        end else begin
            if (w_issue) r_tag_pipe[0] <= w_head[CmdW-1 -: TagWidth];
            for (int i = 1; i <= ALU_LATENCY; i++) r_tag_pipe[i] <= r_tag_pipe[i-1];
            if (w_res_pop) r_buf_tag[0] <= r_buf_tag[1];
            if (w_cap) r_buf_tag[w_wr_idx] <= r_tag_pipe[ALU_LATENCY];
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vector table plus randomized stream against an
// in-order reference queue; a registered ALU model closes the loop.
module tb_alu_issue;

    typedef struct packed {
        logic [3:0] tag;
        logic       o;
        logic [7:0] d;
    } exp_t;

    typedef struct {
        logic [1:0] opc;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_opc = 2'd0;
    logic [7:0] cmd_a = 8'd0;
    logic [7:0] cmd_b = 8'd0;
    logic [1:0] alu_opc;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_dout = 8'd0;
    logic       alu_ovf = 1'b0;
    logic [8:0] alu_r;
    logic       res_valid;
    logic       res_ready = 1'b1;
    logic [7:0] res_data;
    logic       res_ovf;
`ifdef ALU_ISSUE_TAG_EN
    logic [3:0] cmd_tag = 4'd0;
    logic [3:0] res_tag;
`endif

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    bit   rand_mode = 1'b0;
    logic [3:0] tag_n = 4'd1;
    vec_t tbl[5];

    always #5 clk = ~clk;

    // Stand-in for the ALU: one-cycle registered result, carry/borrow as overflow.
    always_comb begin
        case (alu_opc)
            2'd0:    alu_r = {1'b0, alu_a} + {1'b0, alu_b};
            2'd1:    alu_r = {1'b0, alu_a} - {1'b0, alu_b};
            2'd2:    alu_r = {1'b0, alu_a & alu_b};
            default: alu_r = {1'b0, alu_a | alu_b};
        endcase
    end

    always @(posedge clk) {alu_ovf, alu_dout} <= alu_r;

    alu_issue #(
        .Width(8),
        .Depth(4)
    ) dut (
        .Clk_i       (clk),
        .Reset_n_i   (rst_n),
        .Cmd_valid_i (cmd_valid),
        .Cmd_ready_o (cmd_ready),
        .Cmd_opc_i   (cmd_opc),
        .Cmd_a_i     (cmd_a),
        .Cmd_b_i     (cmd_b),
        .Alu_opc_o   (alu_opc),
        .Alu_a_o     (alu_a),
        .Alu_b_o     (alu_b),
        .Alu_dout_i  (alu_dout),
        .Alu_ovf_i   (alu_ovf),
        .Res_valid_o (res_valid),
        .Res_ready_i (res_ready),
        .Res_data_o  (res_data),
`ifdef ALU_ISSUE_TAG_EN
        .Cmd_tag_i   (cmd_tag),
        .Res_tag_o   (res_tag),
`endif
        .Res_ovf_o   (res_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    function automatic exp_t model(input logic [1:0] opc, input logic [7:0] a, input logic [7:0] b,
                                   input logic [3:0] tag);
        int   s;
        exp_t e;
        case (opc)
            2'd0:    s = int'(a) + int'(b);
            2'd1:    s = int'(a) - int'(b);
            2'd2:    s = int'(a & b);
            default: s = int'(a | b);
        endcase
        e.d   = s[7:0];
        e.o   = (opc < 2'd2) && (s < 0 || s > 255);
        e.tag = tag;
        return e;
    endfunction

    task automatic send(input logic [1:0] opc, input logic [7:0] a, input logic [7:0] b, input exp_t e);
        cmd_valid = 1'b1;
        cmd_opc   = opc;
        cmd_a     = a;
        cmd_b     = b;
`ifdef ALU_ISSUE_TAG_EN
        cmd_tag   = e.tag;
`endif
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        check("cmd_accept", cmd_ready, 1);
        if (cmd_ready) exp_q.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        tag_n = tag_n + 4'd1;
    endtask

    task automatic send_m(input logic [1:0] opc, input logic [7:0] a, input logic [7:0] b);
        send(opc, a, b, model(opc, a, b, tag_n));
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted result must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_result: got %0h expected none", res_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", {res_ovf, res_data}, {e.o, e.d});
`ifdef ALU_ISSUE_TAG_EN
                check("result_tag", res_tag, e.tag);
`endif
            end
        end
    end

    initial begin
        tbl[0] = '{2'd0, 8'h0F, 8'h01, 8'h10, 1'b0};
        tbl[1] = '{2'd0, 8'hFF, 8'h01, 8'h00, 1'b1};
        tbl[2] = '{2'd1, 8'h00, 8'h01, 8'hFF, 1'b1};
        tbl[3] = '{2'd2, 8'hF0, 8'h3C, 8'h30, 1'b0};
        tbl[4] = '{2'd3, 8'h0F, 8'h30, 8'h3F, 1'b0};

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res", {res_ovf, res_data}, 0);
        check("rst_alu", {alu_opc, alu_a, alu_b}, 0);
`ifdef ALU_ISSUE_TAG_EN
        check("rst_res_tag", res_tag, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single ADD: result appears three cycles after acceptance.
        send(tbl[0].opc, tbl[0].a, tbl[0].b, {tag_n, tbl[0].o, tbl[0].d});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("latency_c%0d", c), res_valid, c == 3);
        end
        drain();

        for (int i = 1; i < 5; i++) send(tbl[i].opc, tbl[i].a, tbl[i].b, {tag_n, tbl[i].o, tbl[i].d});
        drain();

        // Backpressure: two results held, FIFO fills, then everything drains.
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_m(2'(i % 4), 8'(8'h70 + 8'(i * 37)), 8'(8'h95 + 8'(i * 13)));
        repeat (4) @(negedge clk);
        check("bp_cmd_ready", cmd_ready, 0);
        check("bp_res_valid", res_valid, 1);
        @(posedge clk);
        #1 res_ready = 1'b1;
        drain();

        // Push and result pop in the same cycle with FIFO at three and outstanding two.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_m(2'd1, 8'(i * 50), 8'(8'h33 + 8'(i)));
        repeat (4) @(posedge clk);
        #1 res_ready = 1'b1;
        send_m(2'd0, 8'hC8, 8'h64);
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("pp_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1 res_ready = 1'b1;
        drain();

        // Reset in the middle of traffic discards everything.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_m(2'd3, 8'h11, 8'(8'h22 + 8'(i)));
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_res_valid", res_valid, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_alu_a", alu_a, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        send(2'd0, 8'h02, 8'h03, {tag_n, 1'b0, 8'h05});
        drain();
        repeat (6) @(negedge clk);
        check("post_rst_idle", res_valid, 0);
        @(posedge clk);
        #1;

        // Randomized stream with random result backpressure.
        rand_mode = 1'b1;
        fork
            while (rand_mode) begin
                @(posedge clk);
                #1 res_ready = $urandom_range(0, 3) != 0;
            end
        join_none
        for (int i = 0; i < 250; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_m(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #2 res_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
